alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer that shares one ALU datapath (ctrl codes 0 AND, 1 OR, 2 ADD, 6 SUB, 7 signed SLT, 12 NOR, others → 0) between two independent issuers, e.g. a main pipeline and a multi-cycle helper unit. It accepts one operation at a time over valid/ready, registers the operands and computes in a dedicated execute cycle. It returns a tagged, registered result over a backpressurable response channel, and keeps a wrapping count of completed operations.

## Interface
- CNT_W, 16, width of completed-operation counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req0_src1_i / req0_src2_i  in  32 each  requester 0 operands (signed)
- req0_ctrl_i  in  4  requester 0 ALU control code
- req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i: same as requester 0
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_id_o  out  1  requester index owning the response
- rsp_result_o  out  32  ALU result
- rsp_zero_o  out  1  rsp_result_o == 0
- busy_o  out  1  state != IDLE
- op_count_o  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant computed combinationally from the valids; reqN_ready_o = (state==IDLE) && grant==N && reqN_valid_i. On a handshake: latch src1, src2, ctrl and id into operand registers, update last_grant, go to EXEC. No valid: stay in IDLE.
- EXEC: ALU evaluates the operand registers. At the clock edge: result → rsp_result_o, zero → rsp_zero_o, id → rsp_id_o, rsp_valid_o←1, go to RESP.
- RESP: hold all rsp_* stable. When rsp_valid_o && rsp_ready_i: rsp_valid_o←0, op_count_o←op_count_o+1, go to IDLE.
- Arithmetic: ADD/SUB are 32-bit modulo with no carry or overflow output. SLT compares signed and returns 1 or 0. An undefined ctrl gives result 0 and zero 1; it is not an error.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is legal: no operation is taken.
- No combinational path from rsp_ready_i to any req*_ready_o.

## Timing
- Reset values: req*_ready_o 0 (while in reset), rsp_valid_o 0, rsp_id_o 0, rsp_result_o 0, rsp_zero_o 0, busy_o 0, op_count_o 0, state IDLE, last_grant 1 (requester 0 wins the first tie).
- Latency: handshake at edge N → rsp_valid_o high after edge N+1.
- Minimum issue interval: 3 cycles (accept, execute, response handshake with rsp_ready_i already high). The next grant is decided in the cycle after the response handshake.
- Backpressure: a response waits indefinitely in RESP and the inputs stay blocked.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is produced, and all outputs immediately take their reset values.
- Simultaneous valids: resolved per Configuration. A lone valid is always granted in the same cycle.
- op_count_o wraps from 2^CNT_W−1 to 0.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: with both requesters valid, the grant goes to the requester that is not last_grant.
- Undefined: fixed priority, requester 0 always wins and last_grant is ignored.

## Test plan
- req0: ctrl=2, src1=5, src2=7 → req0_ready_o in cycle 0, rsp_valid_o after edge 1, result 12, id 0, zero 0.
- Both valids held high for 4 ops, rsp_ready_i=1 → grant order 0,1,0,1 with the macro; 0,0,0,0 without it.
- req1: ctrl=7, src1=0xFFFFFFFF, src2=1 → result 1. Then ctrl=6, 5−5 → result 0, zero 1. Then ctrl=12, 0,0 → 0xFFFFFFFF. Then ctrl=3 → result 0, zero 1.
- rsp_ready_i low for 5 cycles with req0 and req1 valid → response fields stable, both ready_o low, busy_o 1. Raising rsp_ready_i completes the response; the next grant comes one cycle later.
- rst_i pulsed mid-EXEC → rsp_valid_o stays 0, op_count_o 0, and the next request is served normally with last_grant reset.
- CNT_W=4, 17 completed ops → op_count_o reads 1 (wrapped).

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and status bundle for alu_arbiter.
// The master side is the pair of issuers plus the response consumer; the
// slave side is the arbiter itself.
interface alu_arbiter_if #(
  parameter int CNT_W = 16
);
  // requester 0
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [31:0]      req0_src1_i;
  logic [31:0]      req0_src2_i;
  logic [3:0]       req0_ctrl_i;
  // requester 1
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [31:0]      req1_src1_i;
  logic [31:0]      req1_src2_i;
  logic [3:0]       req1_ctrl_i;
  // response channel
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_id_o;
  logic [31:0]      rsp_result_o;
  logic             rsp_zero_o;
  // status
  logic             busy_o;
  logic [CNT_W-1:0] op_count_o;

  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output rsp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o,
    input  busy_o, op_count_o
  );

  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  rsp_ready_i,
    output req0_ready_o, req1_ready_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o,
    output busy_o, op_count_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter sharing one ALU. One operation is in
// flight at a time: accept (IDLE) -> execute (EXEC) -> hold response (RESP).
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN. When defined, simultaneous
// requests alternate using last_grant; when undefined, requester 0 always
// wins a tie.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] CTRL_AND = 4'd0;
  localparam logic [3:0] CTRL_OR  = 4'd1;
  localparam logic [3:0] CTRL_ADD = 4'd2;
  localparam logic [3:0] CTRL_SUB = 4'd6;
  localparam logic [3:0] CTRL_SLT = 4'd7;
  localparam logic [3:0] CTRL_NOR = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      op_src1;
  logic [31:0]      op_src2;
  logic [3:0]       op_ctrl;
  logic             op_id;
  logic             rsp_valid;
  logic             rsp_id;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [CNT_W-1:0] op_count;
  logic             grant;
  logic             take;
  logic [31:0]      alu_result;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic             last_grant;
`endif

  // Pick a requester from the current valids; a lone valid always wins.
  always_comb begin
    grant = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant = ~last_grant;
    end else if (bus.req1_valid_i) begin
      grant = 1'b1;
    end
`else
    if (!bus.req0_valid_i && bus.req1_valid_i) begin
      grant = 1'b1;
    end
`endif
  end

  // Handshake happens only in IDLE; reset forces ready low immediately.
  assign take = !rst_i && (state == IDLE) &&
                (grant ? bus.req1_valid_i : bus.req0_valid_i);

  assign bus.req0_ready_o = take && !grant;
  assign bus.req1_ready_o = take && grant;

  // Shared ALU evaluated on the registered operands.
  always_comb begin
    alu_result = 32'd0;
    case (op_ctrl)
      CTRL_AND: alu_result = op_src1 & op_src2;
      CTRL_OR:  alu_result = op_src1 | op_src2;
      CTRL_ADD: alu_result = op_src1 + op_src2;
      CTRL_SUB: alu_result = op_src1 - op_src2;
      CTRL_SLT: alu_result = {31'd0, ($signed(op_src1) < $signed(op_src2))};
      CTRL_NOR: alu_result = ~(op_src1 | op_src2);
      default:  alu_result = 32'd0;
    endcase
  end

  // Sequencer: latch operands, execute, then hold the response until taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op_src1    <= 32'd0;
      op_src2    <= 32'd0;
      op_ctrl    <= 4'd0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_src1 <= grant ? bus.req1_src1_i : bus.req0_src1_i;
            op_src2 <= grant ? bus.req1_src2_i : bus.req0_src2_i;
            op_ctrl <= grant ? bus.req1_ctrl_i : bus.req0_ctrl_i;
            op_id   <= grant;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant <= grant;
`endif
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= (alu_result == 32'd0);
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_valid && bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_id_o     = rsp_id;
  assign bus.rsp_result_o = rsp_result;
  assign bus.rsp_zero_o   = rsp_zero;
  assign bus.busy_o       = (state != IDLE);
  assign bus.op_count_o   = op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, ALU results, response
// backpressure, reset mid-operation and counter wrap (CNT_W = 4).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_count;

  alu_arbiter_if #(.CNT_W(4)) bus ();

  alu_arbiter #(.CNT_W(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_valids();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
  endtask

  task automatic idle_inputs();
    idle_valids();
    bus.req0_src1_i = 32'd0; bus.req0_src2_i = 32'd0; bus.req0_ctrl_i = 4'd0;
    bus.req1_src1_i = 32'd0; bus.req1_src2_i = 32'd0; bus.req1_ctrl_i = 4'd0;
    bus.rsp_ready_i = 1'b0;
  endtask

  // Issue one operation and collect its response (rsp_ready held high).
  task automatic run_op(input logic id, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic zr,
                        output logic rid, output logic ok);
    int n;
    ok = 1'b0; res = 32'd0; zr = 1'b0; rid = 1'b0; n = 0;
    bus.rsp_ready_i = 1'b1;
    if (id) begin
      bus.req1_valid_i = 1'b1; bus.req1_ctrl_i = ctrl;
      bus.req1_src1_i = a;     bus.req1_src2_i = b;
    end else begin
      bus.req0_valid_i = 1'b1; bus.req0_ctrl_i = ctrl;
      bus.req0_src1_i = a;     bus.req0_src2_i = b;
    end
    #1;
    while (!(id ? bus.req1_ready_o : bus.req0_ready_o) && n < 20) begin
      step(); #1; n++;
    end
    if (n >= 20) begin
      idle_valids();
      return;
    end
    step();
    idle_valids();
    #1;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin
      step(); #1; n++;
    end
    if (n >= 20) return;
    res = bus.rsp_result_o;
    zr  = bus.rsp_zero_o;
    rid = bus.rsp_id_o;
    step(); #1;
    exp_count++;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    step(); step(); #1;
    checks++; if (bus.req0_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %0h exp 0", bus.req0_ready_o); end
    checks++; if (bus.req1_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %0h exp 0", bus.req1_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_id_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %0h exp 0", bus.rsp_id_o); end
    checks++; if (bus.rsp_result_o !== 32'd0) begin errors++; $display("FAIL reset_rsp_result got %0h exp 0", bus.rsp_result_o); end
    checks++; if (bus.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got %0h exp 0", bus.rsp_zero_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.busy_o); end
    checks++; if (bus.op_count_o !== 4'd0) begin errors++; $display("FAIL reset_op_count got %0h exp 0", bus.op_count_o); end
    idle_valids();
    rst = 1'b0;
    exp_count = 4'd0;
    step();
    $display("test_reset done");
  endtask

  // Both requesters held valid for four operations.
  task automatic test_both_valid();
    logic [3:0] exp_order;
    int got, rsp_cnt, n;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    got = 0; rsp_cnt = 0; n = 0;
    bus.req0_ctrl_i = 4'd2; bus.req0_src1_i = 32'd5;    bus.req0_src2_i = 32'd7;
    bus.req1_ctrl_i = 4'd0; bus.req1_src1_i = 32'hF0;   bus.req1_src2_i = 32'h3C;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    bus.rsp_ready_i = 1'b1;
    #1;
    while (rsp_cnt < 4 && n < 40) begin
      if (got < 4 && (bus.req0_ready_o || bus.req1_ready_o)) begin
        checks++; if (bus.req0_ready_o && bus.req1_ready_o) begin errors++; $display("FAIL both_ready got 11 exp one-hot"); end
        checks++; if (bus.req1_ready_o !== exp_order[got]) begin errors++; $display("FAIL grant_order[%0d] got %0h exp %0h", got, bus.req1_ready_o, exp_order[got]); end
        $display("grant %0d -> requester %0d", got, bus.req1_ready_o);
        got++;
      end
      if (bus.rsp_valid_o) begin
        checks++; if (bus.rsp_id_o !== exp_order[rsp_cnt]) begin errors++; $display("FAIL rr_rsp_id[%0d] got %0h exp %0h", rsp_cnt, bus.rsp_id_o, exp_order[rsp_cnt]); end
        checks++; if (bus.rsp_result_o !== (exp_order[rsp_cnt] ? 32'h30 : 32'd12)) begin errors++; $display("FAIL rr_rsp_result[%0d] got %0h exp %0h", rsp_cnt, bus.rsp_result_o, (exp_order[rsp_cnt] ? 32'h30 : 32'd12)); end
        rsp_cnt++;
        exp_count++;
      end
      step(); #1;
      if (got == 4) idle_valids();
      n++;
    end
    idle_valids();
    checks++; if (rsp_cnt != 4) begin errors++; $display("FAIL both_valid_timeout got %0d exp 4", rsp_cnt); end
    checks++; if (bus.op_count_o !== exp_count) begin errors++; $display("FAIL both_valid_count got %0h exp %0h", bus.op_count_o, exp_count); end
    $display("test_both_valid done");
  endtask

  // Single ADD on requester 0 with exact cycle latency.
  task automatic test_add();
    bus.rsp_ready_i = 1'b1;
    bus.req0_ctrl_i = 4'd2; bus.req0_src1_i = 32'd5; bus.req0_src2_i = 32'd7;
    bus.req0_valid_i = 1'b1;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1) begin errors++; $display("FAIL add_ready0 got %0h exp 1", bus.req0_ready_o); end
    checks++; if (bus.req1_ready_o !== 1'b0) begin errors++; $display("FAIL add_ready1 got %0h exp 0", bus.req1_ready_o); end
    step();
    idle_valids();
    #1;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL add_exec_valid got %0h exp 0", bus.rsp_valid_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL add_exec_busy got %0h exp 1", bus.busy_o); end
    step(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got %0h exp 1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_result_o !== 32'd12) begin errors++; $display("FAIL add_result got %0h exp c", bus.rsp_result_o); end
    checks++; if (bus.rsp_id_o !== 1'b0) begin errors++; $display("FAIL add_id got %0h exp 0", bus.rsp_id_o); end
    checks++; if (bus.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL add_zero got %0h exp 0", bus.rsp_zero_o); end
    step(); #1;
    exp_count++;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL add_done_valid got %0h exp 0", bus.rsp_valid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL add_done_busy got %0h exp 0", bus.busy_o); end
    checks++; if (bus.op_count_o !== exp_count) begin errors++; $display("FAIL add_count got %0h exp %0h", bus.op_count_o, exp_count); end
    $display("test_add done");
  endtask

  // ALU function table across both requesters.
  task automatic test_alu_ops();
    logic        ids   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  ctrls [6] = '{4'd7, 4'd6, 4'd12, 4'd3, 4'd1, 4'd6};
    logic [31:0] as    [6] = '{32'hFFFFFFFF, 32'd5, 32'd0, 32'hAB, 32'hA0, 32'd0};
    logic [31:0] bs    [6] = '{32'd1, 32'd5, 32'd0, 32'hCD, 32'h0B, 32'd1};
    logic [31:0] exps  [6] = '{32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hAB, 32'hFFFFFFFF};
    logic [31:0] res;
    logic zr, rid, ok;
    for (int i = 0; i < 6; i++) begin
      run_op(ids[i], ctrls[i], as[i], bs[i], res, zr, rid, ok);
      checks++; if (!ok) begin errors++; $display("FAIL alu_timeout[%0d] got 0 exp 1", i); end
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL alu_result[%0d] got %0h exp %0h", i, res, exps[i]); end
      checks++; if (zr !== (exps[i] == 32'd0)) begin errors++; $display("FAIL alu_zero[%0d] got %0h exp %0h", i, zr, (exps[i] == 32'd0)); end
      checks++; if (rid !== ids[i]) begin errors++; $display("FAIL alu_id[%0d] got %0h exp %0h", i, rid, ids[i]); end
      $display("alu op %0d ctrl %0d -> %h", i, ctrls[i], res);
    end
    checks++; if (bus.op_count_o !== exp_count) begin errors++; $display("FAIL alu_count got %0h exp %0h", bus.op_count_o, exp_count); end
  endtask

  // Response held under backpressure while both requesters wait.
  task automatic test_backpressure();
    logic exp_next;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_next = 1'b1;
`else
    exp_next = 1'b0;
`endif
    bus.rsp_ready_i = 1'b0;
    bus.req0_ctrl_i = 4'd2; bus.req0_src1_i = 32'd1; bus.req0_src2_i = 32'd2;
    bus.req0_valid_i = 1'b1;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %0h exp 1", bus.req0_ready_o); end
    step();
    bus.req0_ctrl_i = 4'd6; bus.req0_src1_i = 32'd9; bus.req0_src2_i = 32'd4;
    bus.req1_ctrl_i = 4'd1; bus.req1_src1_i = 32'd3; bus.req1_src2_i = 32'd4;
    bus.req1_valid_i = 1'b1;
    #1;
    step(); #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h exp 1", i, bus.rsp_valid_o); end
      checks++; if (bus.rsp_result_o !== 32'd3) begin errors++; $display("FAIL bp_result[%0d] got %0h exp 3", i, bus.rsp_result_o); end
      checks++; if (bus.rsp_id_o !== 1'b0) begin errors++; $display("FAIL bp_id[%0d] got %0h exp 0", i, bus.rsp_id_o); end
      checks++; if (bus.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL bp_zero[%0d] got %0h exp 0", i, bus.rsp_zero_o); end
      checks++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 00", i, {bus.req1_ready_o, bus.req0_ready_o}); end
      checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d] got %0h exp 1", i, bus.busy_o); end
      $display("backpressure cycle %0d held", i);
      step(); #1;
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin errors++; $display("FAIL bp_comb_ready got %b exp 00", {bus.req1_ready_o, bus.req0_ready_o}); end
    step(); #1;
    exp_count++;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0h exp 0", bus.rsp_valid_o); end
    checks++; if (bus.op_count_o !== exp_count) begin errors++; $display("FAIL bp_count got %0h exp %0h", bus.op_count_o, exp_count); end
    checks++; if (bus.req1_ready_o !== exp_next) begin errors++; $display("FAIL bp_next_ready1 got %0h exp %0h", bus.req1_ready_o, exp_next); end
    checks++; if (bus.req0_ready_o !== ~exp_next) begin errors++; $display("FAIL bp_next_ready0 got %0h exp %0h", bus.req0_ready_o, ~exp_next); end
    idle_valids();
    #1;
    step(); #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL bp_drop_busy got %0h exp 0", bus.busy_o); end
    $display("test_backpressure done");
  endtask

  // Reset while an operation is executing.
  task automatic test_reset_mid();
    bus.rsp_ready_i = 1'b1;
    bus.req0_ctrl_i = 4'd2; bus.req0_src1_i = 32'd2; bus.req0_src2_i = 32'd3;
    bus.req0_valid_i = 1'b1;
    #1;
    step();
    idle_valids();
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rm_exec_busy got %0h exp 1", bus.busy_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rm_valid got %0h exp 0", bus.rsp_valid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rm_busy got %0h exp 0", bus.busy_o); end
    checks++; if (bus.op_count_o !== 4'd0) begin errors++; $display("FAIL rm_count got %0h exp 0", bus.op_count_o); end
    rst = 1'b0;
    exp_count = 4'd0;
    step(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rm_no_rsp got %0h exp 0", bus.rsp_valid_o); end
    bus.req0_ctrl_i = 4'd0; bus.req0_src1_i = 32'hFF; bus.req0_src2_i = 32'h0F;
    bus.req1_ctrl_i = 4'd2; bus.req1_src1_i = 32'd1;  bus.req1_src2_i = 32'd1;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    #1;
    checks++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin errors++; $display("FAIL rm_grant got %b exp 01", {bus.req1_ready_o, bus.req0_ready_o}); end
    step();
    idle_valids();
    step(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rm_rsp_valid got %0h exp 1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_result_o !== 32'h0F) begin errors++; $display("FAIL rm_result got %0h exp f", bus.rsp_result_o); end
    step(); #1;
    exp_count++;
    checks++; if (bus.op_count_o !== 4'd1) begin errors++; $display("FAIL rm_count_after got %0h exp 1", bus.op_count_o); end
    $display("test_reset_mid done");
  endtask

  // 17 completed operations since reset: counter wraps 15 -> 0 -> 1.
  task automatic test_wrap();
    logic [31:0] res;
    logic zr, rid, ok;
    for (int i = 0; i < 15; i++) begin
      run_op(i[0], 4'd2, i, 32'd1, res, zr, rid, ok);
      checks++; if (!ok || res !== i + 1) begin errors++; $display("FAIL wrap_op[%0d] got %0h exp %0h", i, res, i + 1); end
    end
    checks++; if (bus.op_count_o !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0h exp 0", bus.op_count_o); end
    run_op(1'b0, 4'd2, 32'd20, 32'd22, res, zr, rid, ok);
    checks++; if (!ok || res !== 32'd42) begin errors++; $display("FAIL wrap_last got %0h exp 2a", res); end
    checks++; if (bus.op_count_o !== 4'd1) begin errors++; $display("FAIL wrap_count got %0h exp 1", bus.op_count_o); end
    $display("test_wrap count %0d", bus.op_count_o);
  endtask

  initial begin
    test_reset();
    test_both_valid();
    test_add();
    test_alu_ops();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
